axi_stream_frame_dma: RTL

//  Parametrised AXI4 read-master DMA. Streams a frame buffer from memory onto an Avalon-ST-style video/packet stream.

---
 rtl/axi_stream_frame_dma.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_stream_frame_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_stream_frame_dma                                         |
// | Description : AXI4 read-master frame DMA. Fetches a frame buffer from      |
// |               memory in INCR bursts and streams it out as an Avalon-ST     |
// |               style packet (SOP on the first beat, EOP on the last).       |
// |               Single-shot or continuous frame mode, frames-done counter    |
// |               and a per-frame completion interrupt.                        |
// | Options     : `define AXI_STREAM_DMA_ERR_EN to turn non-OKAY read          |
// |               responses into a sticky error that aborts the frame.         |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               m_axi_ar*  : AR channel (id 0, INCR, size log2(BYTES))       |
// |               m_axi_r*   : R channel, rready = st_ready                    |
// |               st_*       : stream out, data/valid pass straight through    |
// |               ctrl_*     : register port (0x0 START_ADDR, 0x4 FRAME_BEATS, |
// |                            0x8 CTRL, 0xC STATUS), read data 1 cycle late  |
// |               irq_frame_done : 1-cycle pulse per completed frame           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_stream_frame_dma #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [3:0]            m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_valid,
  output logic                  st_startofpacket,
  output logic                  st_endofpacket,
  input  logic                  st_ready,
  input  logic [3:0]            ctrl_address,
  input  logic                  ctrl_write,
  input  logic [31:0]           ctrl_writedata,
  input  logic                  ctrl_read,
  output logic [31:0]           ctrl_readdata,
  output logic                  irq_frame_done
);

  localparam int                   c_bytes     = DATA_WIDTH / 8;
  localparam int                   c_ost_w     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_WIDTH-1:0] c_burst_len = LEN_WIDTH'(BURST_LEN);
  localparam logic [c_ost_w-1:0]   c_max_ost   = c_ost_w'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  // Programmer-visible registers
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic [LEN_WIDTH-1:0]  r_frame_beats;
  logic                  r_enable;
  logic                  r_continuous;
  logic [15:0]           r_frames_done;
  logic                  w_error_bit;

  // Working copies for the frame in flight
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem_ar;
  logic [LEN_WIDTH-1:0]  r_frame_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic [c_ost_w-1:0]    r_ost;
  logic                  r_ar_hold;
  logic                  r_rx_done;
  logic                  r_aborted;
  logic                  r_irq;
  logic [31:0]           r_readdata;

  logic [LEN_WIDTH-1:0]  w_burst;
  logic                  w_arvalid;
  logic                  w_ar_fire;
  logic                  w_r_fire;
  logic                  w_rlast_fire;
  logic                  w_eop_beat;
  logic                  w_err;
  logic                  w_done;
  logic                  w_latch;
  logic                  w_abort;

  assign w_burst      = (r_rem_ar >= c_burst_len) ? c_burst_len : r_rem_ar;
  // A request that has been presented stays up until accepted, even if the
  // enable or the outstanding budget changes underneath it.
  assign w_arvalid    = (r_state == S_ISSUE) && (r_rem_ar != '0) &&
                        (r_ar_hold || (r_enable && (r_ost < c_max_ost)));
  assign w_ar_fire    = w_arvalid && m_axi_arready;
  assign w_r_fire     = m_axi_rvalid && st_ready;
  assign w_rlast_fire = w_r_fire && m_axi_rlast;
  assign w_eop_beat   = (r_beat_cnt == (r_frame_len - 1'b1));
  assign w_done       = (r_state == S_DRAIN) && (r_ost == '0) && r_rx_done && !r_aborted;

`ifdef AXI_STREAM_DMA_ERR_EN
  logic r_error;
  assign w_err       = w_r_fire && (m_axi_rresp != 2'b00);
  assign w_error_bit = r_error;
`else
  logic w_rresp_unused;
  assign w_rresp_unused = ^m_axi_rresp;
  assign w_err          = 1'b0;
  assign w_error_bit    = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_enable && (r_frame_beats != '0)) begin
          w_state_next = S_ISSUE;
          w_latch      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_ar_fire && (r_rem_ar == w_burst)) begin
          w_state_next = S_DRAIN;
        end else if (!r_enable && !r_ar_hold) begin
          w_state_next = S_DRAIN;
          w_abort      = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_ost == '0) begin
          if (r_aborted) begin
            w_state_next = S_IDLE;
          end else if (r_rx_done) begin
            if (r_enable && r_continuous && (r_frame_beats != '0)) begin
              w_state_next = S_ISSUE;
              w_latch      = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath / frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem_ar    <= '0;
      r_frame_len <= '0;
      r_beat_cnt  <= '0;
      r_ost       <= '0;
      r_ar_hold   <= 1'b0;
      r_rx_done   <= 1'b0;
      r_aborted   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ar_hold <= w_arvalid && !m_axi_arready;
      r_irq     <= w_done;

      if (w_latch) begin
        r_addr      <= r_start_addr;
        r_rem_ar    <= r_frame_beats;
        r_frame_len <= r_frame_beats;
      end else if (w_ar_fire) begin
        r_addr   <= r_addr + (ADDR_WIDTH'(w_burst) * ADDR_WIDTH'(c_bytes));
        r_rem_ar <= r_rem_ar - w_burst;
      end

      // An AR accept and a burst completion in the same cycle cancel out.
      if (w_ar_fire && !w_rlast_fire) begin
        r_ost <= r_ost + 1'b1;
      end else if (!w_ar_fire && w_rlast_fire) begin
        r_ost <= r_ost - 1'b1;
      end

      // Cleared in IDLE so an aborted frame never leaves a stale position.
      if (w_latch || (r_state == S_IDLE)) begin
        r_beat_cnt <= '0;
      end else if (w_r_fire) begin
        r_beat_cnt <= w_eop_beat ? '0 : (r_beat_cnt + 1'b1);
      end

      if (w_latch) begin
        r_rx_done <= 1'b0;
      end else if (w_r_fire && w_eop_beat) begin
        r_rx_done <= 1'b1;
      end

      if (w_latch) begin
        r_aborted <= 1'b0;
      end else if (w_abort || (w_err && (r_state != S_IDLE))) begin
        r_aborted <= 1'b1;
      end
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_addr  <= '0;
      r_frame_beats <= '0;
      r_enable      <= 1'b0;
      r_continuous  <= 1'b0;
      r_frames_done <= '0;
`ifdef AXI_STREAM_DMA_ERR_EN
      r_error       <= 1'b0;
`endif
    end else begin
      if (ctrl_write) begin
        case (ctrl_address)
          4'h0: r_start_addr  <= ADDR_WIDTH'(ctrl_writedata);
          4'h4: r_frame_beats <= ctrl_writedata[LEN_WIDTH-1:0];
          4'h8: begin
            r_enable     <= ctrl_writedata[0];
            r_continuous <= ctrl_writedata[1];
          end
`ifdef AXI_STREAM_DMA_ERR_EN
          4'hC: if (ctrl_writedata[1]) r_error <= 1'b0;
`endif
          default: ;
        endcase
      end

      if (w_done) begin
        r_frames_done <= r_frames_done + 16'd1;
        // Single-shot: the enable is consumed by the frame it started,
        // otherwise IDLE would immediately launch the next one.
        if (!r_continuous) r_enable <= 1'b0;
      end

`ifdef AXI_STREAM_DMA_ERR_EN
      if (w_err) begin
        r_error  <= 1'b1;
        r_enable <= 1'b0;
      end
`endif
    end
  end

  // Read-back, registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_readdata <= '0;
    end else if (ctrl_read) begin
      case (ctrl_address)
        4'h0:    r_readdata <= 32'(r_start_addr);
        4'h4:    r_readdata <= 32'(r_frame_beats);
        4'h8:    r_readdata <= {30'd0, r_continuous, r_enable};
        4'hC:    r_readdata <= {r_frames_done, 14'd0, w_error_bit, (r_state != S_IDLE)};
        default: r_readdata <= '0;
      endcase
    end
  end

  assign m_axi_arid       = 4'd0;
  assign m_axi_araddr     = r_addr;
  assign m_axi_arlen      = 8'(w_burst - 1'b1);
  assign m_axi_arsize     = 3'($clog2(c_bytes));
  assign m_axi_arburst    = 2'b01;
  assign m_axi_arvalid    = w_arvalid;
  assign m_axi_rready     = st_ready;
  assign st_data          = m_axi_rdata;
  assign st_valid         = m_axi_rvalid;
  assign st_startofpacket = (r_beat_cnt == '0) && m_axi_rvalid;
  assign st_endofpacket   = w_eop_beat && m_axi_rvalid;
  assign ctrl_readdata    = r_readdata;
  assign irq_frame_done   = r_irq;

endmodule
`default_nettype wire
